// File: rtl/reorder_buffer_mc.sv
// Reorder buffer: in-order commit queue with N write-back channels, up to 2-wide commit,
// operand query bypass and registered branch-mispredict flush/redirect.
module reorder_buffer_mc #(
   parameter int DEPTH    = 16,
   parameter int IDX_W    = 4,
   parameter int NUM_WB   = 2,
   parameter int COMMIT_W = 1
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       rdy_in,
   input  logic                       iss_valid,
   input  logic                       iss_ready,
   input  logic [1:0]                 iss_type,
   input  logic [31:0]                iss_value,
   input  logic [4:0]                 iss_rd,
   input  logic [31:0]                iss_addr,
   output logic [IDX_W-1:0]           iss_idx,
   output logic                       full,
   output logic [IDX_W:0]             count,
   input  logic [IDX_W-1:0]           q1_idx,
   input  logic [IDX_W-1:0]           q2_idx,
   output logic                       q1_ready,
   output logic                       q2_ready,
   output logic [31:0]                q1_value,
   output logic [31:0]                q2_value,
   input  logic [NUM_WB-1:0]          wb_valid,
   input  logic [NUM_WB*IDX_W-1:0]    wb_idx,
   input  logic [NUM_WB*32-1:0]       wb_value,
   input  logic [NUM_WB-1:0]          wb_mispred,
   output logic [IDX_W-1:0]           head_idx,
   output logic                       head_valid,
   input  logic                       st_ok,
   output logic [COMMIT_W-1:0]        cm_valid,
   output logic [COMMIT_W*5-1:0]      cm_rd,
   output logic [COMMIT_W*32-1:0]     cm_value,
   output logic [COMMIT_W*IDX_W-1:0]  cm_idx,
   output logic                       flush,
   output logic [31:0]                redirect_pc
);

   localparam logic [1:0]     T_RG     = 2'd0;
   localparam logic [1:0]     T_ST     = 2'd1;
   localparam logic [1:0]     T_BR     = 2'd2;
   localparam logic [IDX_W:0] FULL_LVL = (IDX_W+1)'(DEPTH - 1);

   logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, misp_q, misp_d;
   logic [1:0]       type_q  [DEPTH];
   logic [1:0]       type_d  [DEPTH];
   logic [31:0]      value_q [DEPTH];
   logic [31:0]      value_d [DEPTH];
   logic [4:0]       rd_q    [DEPTH];
   logic [4:0]       rd_d    [DEPTH];
   logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             flush_q, flush_d;
   logic [31:0]      redirect_q, redirect_d;

   logic [IDX_W-1:0] head1;
   logic             commit0, commit1, mispred_commit, iss_fire;
   logic [1:0]       commit_vec, n_commit;
   logic [IDX_W-1:0] slot_idx [COMMIT_W];
   logic [IDX_W-1:0] wb_t;

   assign full     = (count_q >= FULL_LVL) | flush_q;
   assign iss_fire = rdy_in & iss_valid & ~full;
   assign head1    = head_q + IDX_W'(1);

   // Slot 1 may only follow a head that cannot redirect or touch memory.
   assign commit0 = rdy_in & ~flush_q & busy_q[head_q] & ready_q[head_q] &
                    ((type_q[head_q] != T_ST) | st_ok);
   assign commit1 = (COMMIT_W == 2) && commit0 &&
                    ((type_q[head_q] == T_RG) || ((type_q[head_q] == T_BR) && !misp_q[head_q])) &&
                    busy_q[head1] && ready_q[head1] && (type_q[head1] == T_RG);
   assign mispred_commit = commit0 & (type_q[head_q] == T_BR) & misp_q[head_q];
   assign commit_vec     = {commit1, commit0};
   assign n_commit       = {1'b0, commit0} + {1'b0, commit1};

   always_comb begin : commit_ports
      cm_valid = '0;
      cm_rd    = '0;
      cm_value = '0;
      cm_idx   = '0;
      for (int s = 0; s < COMMIT_W; s++) begin
         slot_idx[s] = head_q + IDX_W'(s);
         cm_valid[s]                 = commit_vec[s] & (type_q[slot_idx[s]] == T_RG);
         cm_rd[s*5 +: 5]             = rd_q[slot_idx[s]];
         cm_value[s*32 +: 32]        = value_q[slot_idx[s]];
         cm_idx[s*IDX_W +: IDX_W]    = slot_idx[s];
      end
   end

   logic [IDX_W-1:0] q_idx [2];
   logic             q_rdy [2];
   logic [31:0]      q_val [2];

   // Query: stored result, then lowest-numbered write-back, then a ready issue landing at tail.
   always_comb begin : operand_query
      q_idx[0] = q1_idx;
      q_idx[1] = q2_idx;
      for (int q = 0; q < 2; q++) begin
         q_rdy[q] = 1'b0;
         q_val[q] = '0;
         if (ready_q[q_idx[q]]) begin
            q_rdy[q] = 1'b1;
            q_val[q] = value_q[q_idx[q]];
         end else begin
            for (int k = NUM_WB - 1; k >= 0; k--) begin
               if (wb_valid[k] && busy_q[q_idx[q]] && (wb_idx[k*IDX_W +: IDX_W] == q_idx[q])) begin
                  q_rdy[q] = 1'b1;
                  q_val[q] = wb_value[k*32 +: 32];
               end
            end
            if (!q_rdy[q] && iss_fire && iss_ready && (tail_q == q_idx[q])) begin
               q_rdy[q] = 1'b1;
               q_val[q] = iss_value;
            end
         end
      end
   end

   assign q1_ready = q_rdy[0];
   assign q1_value = q_val[0];
   assign q2_ready = q_rdy[1];
   assign q2_value = q_val[1];

   always_comb begin : next_state
      busy_d     = busy_q;
      ready_d    = ready_q;
      misp_d     = misp_q;
      type_d     = type_q;
      value_d    = value_q;
      rd_d       = rd_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      flush_d    = flush_q;
      redirect_d = redirect_q;
      wb_t       = '0;
      if (rdy_in) begin
         if (flush_q) begin
            busy_d  = '0;
            ready_d = '0;
            misp_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            flush_d = 1'b0;
         end else begin
            for (int k = 0; k < NUM_WB; k++) begin
               wb_t = wb_idx[k*IDX_W +: IDX_W];
               if (wb_valid[k] && busy_q[wb_t]) begin
                  ready_d[wb_t] = 1'b1;
                  if (type_q[wb_t] == T_BR) misp_d[wb_t] = wb_mispred[k];
                  else value_d[wb_t] = wb_value[k*32 +: 32];
               end
            end
            for (int s = 0; s < COMMIT_W; s++) begin
               if (commit_vec[s]) begin
                  busy_d[slot_idx[s]]  = 1'b0;
                  ready_d[slot_idx[s]] = 1'b0;
               end
            end
            if (iss_fire) begin
               busy_d[tail_q]  = 1'b1;
               ready_d[tail_q] = iss_ready;
               misp_d[tail_q]  = 1'b0;
               type_d[tail_q]  = iss_type;
               value_d[tail_q] = iss_value;
               rd_d[tail_q]    = iss_rd;
               tail_d          = tail_q + IDX_W'(1);
            end
            head_d  = head_q + IDX_W'(n_commit);
            count_d = count_q + (IDX_W+1)'(iss_fire) - (IDX_W+1)'(n_commit);
            if (mispred_commit) begin
               flush_d    = 1'b1;
               redirect_d = value_q[head_q];
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         busy_q     <= '0;
         ready_q    <= '0;
         misp_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
      end else begin
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         misp_q     <= misp_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
      end
   end

   // Payload needs no reset: busy/ready gate every use of it.
   always_ff @(posedge clk_in) begin
      type_q  <= type_d;
      value_q <= value_d;
      rd_q    <= rd_d;
   end

   assign iss_idx     = tail_q;
   assign count       = count_q;
   assign head_idx    = head_q;
   assign head_valid  = busy_q[head_q];
   assign flush       = flush_q;
   assign redirect_pc = redirect_q;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Bench for reorder_buffer_mc (DEPTH=16, NUM_WB=2, COMMIT_W=2): vector table, directed corner
// sequences and random traffic checked against a queue-based reference model.
module tb_reorder_buffer_mc;

   localparam int DEPTH    = 16;
   localparam int IDX_W    = 4;
   localparam int NUM_WB   = 2;
   localparam int COMMIT_W = 2;

   logic                       clk_in, rst_n_in, rdy_in;
   logic                       iss_valid, iss_ready;
   logic [1:0]                 iss_type;
   logic [31:0]                iss_value, iss_addr;
   logic [4:0]                 iss_rd;
   logic [IDX_W-1:0]           iss_idx;
   logic                       full;
   logic [IDX_W:0]             count;
   logic [IDX_W-1:0]           q1_idx, q2_idx;
   logic                       q1_ready, q2_ready;
   logic [31:0]                q1_value, q2_value;
   logic [NUM_WB-1:0]          wb_valid, wb_mispred;
   logic [NUM_WB*IDX_W-1:0]    wb_idx;
   logic [NUM_WB*32-1:0]       wb_value;
   logic [IDX_W-1:0]           head_idx;
   logic                       head_valid, st_ok;
   logic [COMMIT_W-1:0]        cm_valid;
   logic [COMMIT_W*5-1:0]      cm_rd;
   logic [COMMIT_W*32-1:0]     cm_value;
   logic [COMMIT_W*IDX_W-1:0]  cm_idx;
   logic                       flush;
   logic [31:0]                redirect_pc;

   reorder_buffer_mc #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_type(iss_type), .iss_value(iss_value),
      .iss_rd(iss_rd), .iss_addr(iss_addr), .iss_idx(iss_idx), .full(full), .count(count),
      .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_value(q1_value), .q2_value(q2_value),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value), .wb_mispred(wb_mispred),
      .head_idx(head_idx), .head_valid(head_valid), .st_ok(st_ok),
      .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value), .cm_idx(cm_idx),
      .flush(flush), .redirect_pc(redirect_pc)
   );

   // clock / reset
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int total = 0;
   int bad   = 0;
   logic [IDX_W-1:0] exp_q[$];

   // reference model: the busy entries in age order, oldest first
   typedef struct {
      int       idx;
      bit       rdy;
      bit [1:0] typ;
      bit [31:0] val;
      bit [4:0] rd;
      bit       misp;
   } ent_t;
   ent_t     mq[$];
   int       m_tail;
   bit       m_flush;
   bit [31:0] m_redir;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_full();
      return (mq.size() >= DEPTH - 1) || m_flush;
   endfunction

   function automatic void m_query(input int qi, input bit fire, output bit r, output bit [31:0] v);
      int found;
      r = 0;
      v = 0;
      found = -1;
      foreach (mq[i]) if (mq[i].idx == qi) found = i;
      if (found >= 0 && mq[found].rdy) begin
         r = 1;
         v = mq[found].val;
      end else if (found >= 0) begin
         for (int k = 0; k < NUM_WB; k++) begin
            if (!r && wb_valid[k] && int'(wb_idx[k*IDX_W +: IDX_W]) == qi) begin
               r = 1;
               v = wb_value[k*32 +: 32];
            end
         end
      end
      if (!r && fire && iss_ready && m_tail == qi) begin
         r = 1;
         v = iss_value;
      end
   endfunction

   // driver tasks
   task automatic idle();
      iss_valid = 0; iss_ready = 0; iss_type = 0; iss_value = 0; iss_rd = 0; iss_addr = 0;
      wb_valid = 0; wb_idx = 0; wb_value = 0; wb_mispred = 0;
      st_ok = 0; rdy_in = 1; q1_idx = 0; q2_idx = 0;
   endtask

   task automatic issue(input logic [1:0] t, input logic r, input logic [31:0] v, input logic [4:0] rd);
      iss_valid = 1; iss_type = t; iss_ready = r; iss_value = v; iss_rd = rd;
      iss_addr = $urandom;
   endtask

   task automatic wb(input int k, input int idx, input logic [31:0] v, input logic mp);
      wb_valid[k] = 1'b1;
      wb_idx[k*IDX_W +: IDX_W] = IDX_W'(idx);
      wb_value[k*32 +: 32] = v;
      wb_mispred[k] = mp;
   endtask

   task automatic do_reset();
      idle();
      rst_n_in = 0;
      @(posedge clk_in);
      mq.delete();
      m_tail = 0;
      m_flush = 0;
      m_redir = 0;
      exp_q.delete();
      @(negedge clk_in);
      rst_n_in = 1;
   endtask

   // one clock: compare DUT against the model with the inputs in place, then advance the model
   task automatic step();
      int sz, n;
      bit ef, fire, fl, r;
      bit [31:0] v, br_tgt;
      bit [1:0] ecmv;
      ent_t e;
      #1;
      sz = mq.size();
      ef = m_full();
      fire = rdy_in && iss_valid && !ef;
      n = 0;
      if (rdy_in && !m_flush && sz > 0 && mq[0].rdy && (mq[0].typ != 2'd1 || st_ok)) n = 1;
      if (n == 1 && sz > 1 && (mq[0].typ == 2'd0 || (mq[0].typ == 2'd2 && !mq[0].misp)) &&
          mq[1].rdy && mq[1].typ == 2'd0) n = 2;
      fl = (n > 0) && mq[0].typ == 2'd2 && mq[0].misp;
      br_tgt = (sz > 0) ? mq[0].val : 32'd0;
      ecmv = 0;
      for (int s = 0; s < n; s++) ecmv[s] = (mq[s].typ == 2'd0);
      chk("count", 64'(count), 64'(sz));
      chk("full", 64'(full), 64'(ef));
      chk("head_valid", 64'(head_valid), 64'(sz > 0));
      chk("head_idx", 64'(head_idx), 64'((m_tail - sz) & (DEPTH - 1)));
      chk("iss_idx", 64'(iss_idx), 64'(m_tail));
      chk("cm_valid", 64'(cm_valid), 64'(ecmv));
      for (int s = 0; s < COMMIT_W; s++) begin
         if (ecmv[s]) begin
            chk("cm_rd", 64'(cm_rd[s*5 +: 5]), 64'(mq[s].rd));
            chk("cm_value", 64'(cm_value[s*32 +: 32]), 64'(mq[s].val));
            chk("cm_idx", 64'(cm_idx[s*IDX_W +: IDX_W]), 64'(mq[s].idx));
         end
      end
      chk("flush", 64'(flush), 64'(m_flush));
      if (m_flush) chk("redirect_pc", 64'(redirect_pc), 64'(m_redir));
      m_query(int'(q1_idx), fire, r, v);
      chk("q1_ready", 64'(q1_ready), 64'(r));
      chk("q1_value", 64'(q1_value), 64'(v));
      m_query(int'(q2_idx), fire, r, v);
      chk("q2_ready", 64'(q2_ready), 64'(r));
      chk("q2_value", 64'(q2_value), 64'(v));
      @(posedge clk_in);
      if (rdy_in) begin
         if (m_flush) begin
            mq.delete();
            m_tail = 0;
            m_flush = 0;
         end else begin
            for (int k = 0; k < NUM_WB; k++) begin
               if (wb_valid[k]) begin
                  foreach (mq[i]) begin
                     if (mq[i].idx == int'(wb_idx[k*IDX_W +: IDX_W])) begin
                        mq[i].rdy = 1;
                        if (mq[i].typ == 2'd2) mq[i].misp = wb_mispred[k];
                        else mq[i].val = wb_value[k*32 +: 32];
                     end
                  end
               end
            end
            for (int s = 0; s < n; s++) e = mq.pop_front();
            if (fl) begin
               m_flush = 1;
               m_redir = br_tgt;
            end
            if (fire) begin
               e.idx = m_tail; e.rdy = iss_ready; e.typ = iss_type; e.val = iss_value;
               e.rd = iss_rd; e.misp = 0;
               mq.push_back(e);
               m_tail = (m_tail + 1) % DEPTH;
            end
         end
      end
      @(negedge clk_in);
   endtask

   typedef struct {
      bit        iv;  bit ir;  bit [1:0] it;  bit [31:0] ival;  bit [4:0] ird;
      bit        sok; bit wbv; bit [3:0] wbi; bit [31:0] wbval; bit [3:0] q1;
      int        e_cnt; bit e_hv; bit [1:0] e_cmv; bit [4:0] e_rd; bit [31:0] e_val;
      bit        e_qr;  bit [31:0] e_qv;
   } vec_t;
   vec_t vecs[10];

   initial begin
      bit r;
      bit [1:0] t;
      int n_wrap;

      rst_n_in = 0;
      idle();
      @(negedge clk_in);
      do_reset();
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_head_valid", 64'(head_valid), 64'd0);
      chk("rst_cm_valid", 64'(cm_valid), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
      chk("rst_redirect", 64'(redirect_pc), 64'd0);
      chk("rst_q1_ready", 64'(q1_ready), 64'd0);

      //          iv ir it ival      ird sok wbv wbi wbval    q1 cnt hv cmv rd val      qr qv
      vecs[0] = '{1, 1, 0, 32'h11,   5,  0,  0,  0,  0,       0, 0,  0, 0,  0, 0,       1, 32'h11};
      vecs[1] = '{0, 0, 0, 0,        0,  0,  0,  0,  0,       0, 1,  1, 1,  5, 32'h11,  1, 32'h11};
      vecs[2] = '{0, 0, 0, 0,        0,  0,  0,  0,  0,       0, 0,  0, 0,  0, 0,       0, 0};
      vecs[3] = '{1, 0, 0, 0,        7,  0,  0,  0,  0,       1, 0,  0, 0,  0, 0,       0, 0};
      vecs[4] = '{0, 0, 0, 0,        0,  0,  1,  1,  32'h55,  1, 1,  1, 0,  0, 0,       1, 32'h55};
      vecs[5] = '{0, 0, 0, 0,        0,  0,  0,  0,  0,       1, 1,  1, 1,  7, 32'h55,  1, 32'h55};
      vecs[6] = '{1, 1, 1, 32'h22,   0,  0,  0,  0,  0,       2, 0,  0, 0,  0, 0,       1, 32'h22};
      vecs[7] = '{0, 0, 0, 0,        0,  0,  0,  0,  0,       2, 1,  1, 0,  0, 0,       1, 32'h22};
      vecs[8] = '{0, 0, 0, 0,        0,  1,  0,  0,  0,       2, 1,  1, 0,  0, 0,       1, 32'h22};
      vecs[9] = '{0, 0, 0, 0,        0,  0,  0,  0,  0,       2, 0,  0, 0,  0, 0,       0, 0};
      for (int i = 0; i < 10; i++) begin
         idle();
         if (vecs[i].iv) issue(vecs[i].it, vecs[i].ir, vecs[i].ival, vecs[i].ird);
         if (vecs[i].wbv) wb(0, int'(vecs[i].wbi), vecs[i].wbval, 1'b0);
         st_ok = vecs[i].sok;
         q1_idx = vecs[i].q1;
         #1;
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
         chk($sformatf("vec%0d_head_valid", i), 64'(head_valid), 64'(vecs[i].e_hv));
         chk($sformatf("vec%0d_cm_valid", i), 64'(cm_valid), 64'(vecs[i].e_cmv));
         if (vecs[i].e_cmv[0]) begin
            chk($sformatf("vec%0d_cm_rd", i), 64'(cm_rd[4:0]), 64'(vecs[i].e_rd));
            chk($sformatf("vec%0d_cm_value", i), 64'(cm_value[31:0]), 64'(vecs[i].e_val));
         end
         chk($sformatf("vec%0d_q1_ready", i), 64'(q1_ready), 64'(vecs[i].e_qr));
         chk($sformatf("vec%0d_q1_value", i), 64'(q1_value), 64'(vecs[i].e_qv));
         step();
      end

      // fill to DEPTH-1, then release the head
      do_reset();
      for (int i = 0; i < DEPTH - 1; i++) begin
         idle();
         issue(2'd0, 1'b0, 32'd0, 5'(i));
         step();
      end
      idle();
      #1;
      chk("fill_count", 64'(count), 64'd15);
      chk("fill_full", 64'(full), 64'd1);
      wb(0, 0, 32'd7, 1'b0);
      step();
      idle();
      #1;
      chk("fill_cm_valid", 64'(cm_valid), 64'd1);
      chk("fill_cm_idx", 64'(cm_idx[3:0]), 64'd0);
      chk("fill_cm_value", 64'(cm_value[31:0]), 64'd7);
      step();
      #1;
      chk("fill_full_drop", 64'(full), 64'd0);
      chk("fill_count_after", 64'(count), 64'd14);

      // wrap: issue/commit pairs across the index boundary
      do_reset();
      n_wrap = 0;
      for (int i = 0; i < 42; i++) begin
         idle();
         if (i < 40) begin
            issue(2'd0, 1'b1, $urandom, 5'($urandom_range(0, 31)));
            exp_q.push_back(IDX_W'(m_tail));
         end
         #1;
         chk("wrap_count_bound", 64'(count <= 2), 64'd1);
         if (cm_valid[0]) begin
            if (exp_q.size() == 0) chk("wrap_extra_commit", 64'd1, 64'd0);
            else chk("wrap_cm_idx", 64'(cm_idx[3:0]), 64'(exp_q.pop_front()));
            n_wrap++;
         end
         step();
      end
      chk("wrap_commits", 64'(n_wrap), 64'd40);

      // two-wide commit, then a store stalled on st_ok
      do_reset();
      idle(); issue(2'd0, 1'b0, 32'd0, 5'd1); step();
      idle(); issue(2'd0, 1'b0, 32'd0, 5'd2); step();
      idle(); wb(0, 0, 32'hA1, 1'b0); wb(1, 1, 32'hB2, 1'b0); step();
      idle();
      #1;
      chk("dual_cm_valid", 64'(cm_valid), 64'd3);
      chk("dual_cm_rd", 64'(cm_rd), 64'({5'd2, 5'd1}));
      chk("dual_cm_value", 64'(cm_value), {32'hB2, 32'hA1});
      step();
      idle(); issue(2'd1, 1'b1, 32'h33, 5'd0); step();
      for (int i = 0; i < 3; i++) begin
         idle();
         #1;
         chk("st_head_valid", 64'(head_valid), 64'd1);
         chk("st_no_commit", 64'(cm_valid), 64'd0);
         chk("st_count", 64'(count), 64'd1);
         step();
      end
      idle(); st_ok = 1; step();
      #1;
      chk("st_done_count", 64'(count), 64'd0);

      // branch mispredict with younger ready entries behind it
      do_reset();
      idle(); issue(2'd2, 1'b0, 32'h1000, 5'd0); step();
      for (int i = 0; i < 3; i++) begin
         idle(); issue(2'd0, 1'b1, 32'(i + 1), 5'(i + 3)); step();
      end
      idle(); wb(1, 0, 32'd0, 1'b1); step();
      idle();
      #1;
      chk("br_head_valid", 64'(head_valid), 64'd1);
      step();
      #1;
      chk("br_flush", 64'(flush), 64'd1);
      chk("br_redirect", 64'(redirect_pc), 64'h1000);
      chk("br_full", 64'(full), 64'd1);
      chk("br_no_younger", 64'(cm_valid), 64'd0);
      step();
      #1;
      chk("br_count_cleared", 64'(count), 64'd0);
      chk("br_flush_drop", 64'(flush), 64'd0);

      // write-back bypass to a query
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle(); issue(2'd0, 1'b0, 32'd0, 5'(i)); step();
      end
      idle();
      q1_idx = 3; q2_idx = 2;
      wb(0, 3, 32'hAB, 1'b0);
      #1;
      chk("byp_q1_ready", 64'(q1_ready), 64'd1);
      chk("byp_q1_value", 64'(q1_value), 64'hAB);
      chk("byp_q2_ready", 64'(q2_ready), 64'd0);
      chk("byp_q2_value", 64'(q2_value), 64'd0);
      step();

      // random traffic
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         idle();
         rdy_in = ($urandom_range(0, 7) != 0);
         if (!m_full() && $urandom_range(0, 2) != 0) begin
            r = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: t = 2'd0;
               6, 7:             t = 2'd1;
               default:          t = 2'd2;
            endcase
            issue(t, r, $urandom, 5'($urandom_range(0, 31)));
         end
         for (int k = 0; k < NUM_WB; k++) begin
            if ($urandom_range(0, 1) != 0) begin
               if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                  wb(k, mq[$urandom_range(0, mq.size() - 1)].idx, $urandom, $urandom_range(0, 7) == 0);
               else
                  wb(k, int'($urandom_range(0, DEPTH - 1)), $urandom, $urandom_range(0, 7) == 0);
            end
         end
         if (wb_valid == 2'b11 && wb_idx[3:0] == wb_idx[7:4]) wb_valid[1] = 1'b0;
         st_ok  = $urandom_range(0, 1);
         q1_idx = IDX_W'($urandom_range(0, DEPTH - 1));
         q2_idx = ($urandom_range(0, 1) != 0) ? IDX_W'(m_tail) : IDX_W'($urandom_range(0, DEPTH - 1));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
